// File: rtl/register_dump_unit.sv
// ----------------------------------------------------------------------------
// register_dump_unit
//
// Walks every register of a register bank (address 0 .. 2**ADDR_WIDTH-1),
// reads each word through a combinational read port and streams it to a
// byte-wide UART transmitter, most-significant byte first. Each byte is
// offered with a one-cycle o_tx_start pulse and held on o_tx_data until the
// transmitter acknowledges it with i_tx_done. o_done pulses once after the
// last byte of the last register has been acknowledged.
//
// Ports
//   i_clk       clock, all state changes on the rising edge
//   i_reset     synchronous, active-high reset
//   i_start     request a full dump (only honoured while idle)
//   o_reg_addr  register bank read address
//   i_reg_data  register bank read data for o_reg_addr (same cycle)
//   o_tx_data   byte offered to the transmitter
//   o_tx_start  one-cycle pulse launching transmission of o_tx_data
//   i_tx_done   one-cycle pulse: current byte fully sent
//   o_busy      high whenever a dump is in progress
//   o_done      one-cycle pulse at the end of a dump
// ----------------------------------------------------------------------------
module register_dump_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_reg_addr,
    input  logic [DATA_WIDTH-1:0] i_reg_data,
    output logic [BYTE_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      byte_cnt;
    logic [DATA_WIDTH-1:0] word;

    // Byte k of a word, counted from the most-significant end.
    function automatic logic [BYTE_WIDTH-1:0] byte_of(
        input logic [DATA_WIDTH-1:0] w,
        input logic [CNT_W-1:0]      k
    );
        logic [DATA_WIDTH-1:0] shifted;
        shifted = w << (int'(k) * BYTE_WIDTH);
        return shifted[DATA_WIDTH-1 -: BYTE_WIDTH];
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            o_reg_addr <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            byte_cnt   <= '0;
            word       <= '0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        o_reg_addr <= '0;
                        byte_cnt   <= '0;
                        o_busy     <= 1'b1;
                        state      <= LOAD;
                    end
                end

                // The word register is only written at this edge, so the
                // first byte is taken straight from the read port to have
                // o_tx_data/o_tx_start valid in the SEND cycle itself.
                LOAD: begin
                    word       <= i_reg_data;
                    byte_cnt   <= '0;
                    o_tx_data  <= byte_of(i_reg_data, '0);
                    o_tx_start <= 1'b1;
                    state      <= SEND;
                end

                // i_tx_done is deliberately not looked at here.
                SEND: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (i_tx_done) begin
                        if (byte_cnt < LAST_BYTE) begin
                            byte_cnt   <= byte_cnt + CNT_ONE;
                            o_tx_data  <= byte_of(word, byte_cnt + CNT_ONE);
                            o_tx_start <= 1'b1;
                            state      <= SEND;
                        end else if (o_reg_addr != LAST_ADDR) begin
                            o_reg_addr <= o_reg_addr + ADDR_ONE;
                            state      <= LOAD;
                        end else begin
                            // Address stays at the last register; it is
                            // cleared only by the next accepted i_start.
                            o_done <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end

                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_dump_unit.sv
// ----------------------------------------------------------------------------
// tb_register_dump_unit
//
// Self-checking bench for register_dump_unit with default parameters.
// A register-bank model answers the read port combinationally and a
// transmitter model acknowledges each o_tx_start after a programmable delay.
// Expected bytes are queued when a dump is requested and popped as the DUT
// launches each byte.
// ----------------------------------------------------------------------------
module tb_register_dump_unit;

    localparam int DW         = 32;
    localparam int AW         = 5;
    localparam int BW         = 8;
    localparam int NREGS      = 1 << AW;
    localparam int NBYTES     = DW / BW;
    localparam int DUMP_BYTES = NREGS * NBYTES;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [AW-1:0] o_reg_addr;
    logic [DW-1:0] i_reg_data;
    logic [BW-1:0] o_tx_data;
    logic          o_tx_start;
    logic          i_tx_done;
    logic          o_busy;
    logic          o_done;

    logic [DW-1:0] regs [NREGS];

    int unsigned   n_cmp = 0;
    int unsigned   n_err = 0;

    logic [BW-1:0] exp_q [$];
    int            ack_delay     = 3;
    int            ack_cnt       = 0;
    int            byte_count    = 0;
    int            ack_count     = 0;
    bit            spurious_done = 1'b0;
    longint        cyc           = 0;
    longint        last_ack_cyc  = 0;
    logic [BW-1:0] held_byte     = '0;

    register_dump_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BYTE_WIDTH (BW)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .o_reg_addr (o_reg_addr),
        .i_reg_data (i_reg_data),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    assign i_reg_data = regs[o_reg_addr];

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] expd);
        n_cmp++;
        if (act !== expd) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, expd, $time);
        end
    endtask

    // Transmitter model, evaluated 1 time unit after each rising edge.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            i_tx_done = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    check_eq("tx_hold", 32'(o_tx_data), 32'(held_byte));
                    i_tx_done    = 1'b1;
                    ack_count++;
                    last_ack_cyc = cyc;
                end
            end
            if (o_tx_start === 1'b1) begin
                held_byte = o_tx_data;
                byte_count++;
                if (exp_q.size() == 0) begin
                    check_eq("tx_unexpected_start", 32'(o_tx_start), '0);
                end else begin
                    check_eq("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
                    ack_cnt = ack_delay;
                    if (spurious_done) i_tx_done = 1'b1;
                end
            end
        end
    end

    // Main thread acts 2 time units after each rising edge.
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic push_dump();
        for (int i = 0; i < NREGS; i++)
            for (int k = 0; k < NBYTES; k++)
                exp_q.push_back(BW'(regs[i] >> (BW * (NBYTES - 1 - k))));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_addr"},     32'(o_reg_addr), '0);
        check_eq({tag, "_tx_data"},  32'(o_tx_data),  '0);
        check_eq({tag, "_tx_start"}, 32'(o_tx_start), '0);
        check_eq({tag, "_busy"},     32'(o_busy),     '0);
        check_eq({tag, "_done"},     32'(o_done),     '0);
    endtask

    task automatic start_dump();
        push_dump();
        byte_count = 0;
        i_start    = 1'b1;
        tick();
        i_start = 1'b0;
        check_eq("load_busy",     32'(o_busy),     32'd1);
        check_eq("load_addr",     32'(o_reg_addr), '0);
        check_eq("load_tx_start", 32'(o_tx_start), '0);
        tick();
        check_eq("start_latency", 32'(o_tx_start), 32'd1);
    endtask

    task automatic wait_dump_end(input bit pulse_starts, input bit chain);
        int budget;
        bit seen;
        budget = DUMP_BYTES * (ack_delay + 3) + 50;
        seen   = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (o_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (pulse_starts) i_start = (c % 5 == 0);
            tick();
        end
        i_start = 1'b0;
        check_eq("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check_eq("done_after_last_ack", 32'(cyc), 32'(last_ack_cyc + 1));
            check_eq("dump_byte_count",     32'(byte_count), 32'(DUMP_BYTES));
            check_eq("addr_at_done",        32'(o_reg_addr), 32'(NREGS - 1));
            check_eq("busy_in_done",        32'(o_busy), 32'd1);
            check_eq("queue_drained",       32'(exp_q.size()), '0);
            if (chain) begin
                i_start = 1'b1;
                push_dump();
                byte_count = 0;
            end
            tick();
            check_eq("done_single_pulse", 32'(o_done),     '0);
            check_eq("idle_busy",         32'(o_busy),     '0);
            check_eq("idle_addr_held",    32'(o_reg_addr), 32'(NREGS - 1));
            if (chain) begin
                tick();
                i_start = 1'b0;
                check_eq("chain_busy", 32'(o_busy),     32'd1);
                check_eq("chain_addr", 32'(o_reg_addr), '0);
                tick();
                check_eq("chain_tx_start", 32'(o_tx_start), 32'd1);
            end
        end
    endtask

    initial begin
        int base;
        int target;
        int done_cnt;
        bit reached;

        i_reset = 1'b1;
        i_start = 1'b0;
        for (int i = 0; i < NREGS; i++) regs[i] = 32'h1000_0000 + DW'(i);

        tick();
        tick();
        check_outputs_zero("reset");
        i_reset = 1'b0;
        tick();

        // Full dump, 3-cycle acknowledge.
        ack_delay = 3;
        start_dump();
        wait_dump_end(1'b0, 1'b0);

        // Long acknowledge delay: byte must stay put while waiting.
        ack_delay = 20;
        start_dump();
        wait_dump_end(1'b0, 1'b0);

        // Start requests while busy and acknowledges in the SEND cycle.
        ack_delay     = 3;
        spurious_done = 1'b1;
        start_dump();
        wait_dump_end(1'b1, 1'b0);
        spurious_done = 1'b0;
        tick();

        // Reset once register 5 byte 2 has been acknowledged.
        base = ack_count;
        target = base + NBYTES * 5 + 3;
        start_dump();
        reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (ack_count == target) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        check_eq("midreset_reached", 32'(reached), 32'd1);
        tick();
        i_reset = 1'b1;
        tick();
        check_outputs_zero("midreset");
        check_eq("midreset_bytes_launched", 32'(byte_count), 32'(NBYTES * 5 + 4));
        exp_q.delete();
        ack_cnt = 0;
        i_reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (o_done === 1'b1) done_cnt++;
        end
        check_eq("no_resume_busy", 32'(o_busy), '0);
        check_eq("no_done_after_reset", 32'(done_cnt), '0);
        start_dump();
        wait_dump_end(1'b0, 1'b0);

        // Distinct last register, then start held high through DONE.
        regs[NREGS-1] = 32'hDEAD_BEEF;
        start_dump();
        wait_dump_end(1'b0, 1'b1);
        wait_dump_end(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
